// File: rtl/lsu_mem_stage.sv
// Memory-access stage of the multicycle RV32 core.
// Takes one instruction from EXU and issues at most one data-bus transaction for it.
// Load data is aligned and extended before it is handed to WBU.
// Non-memory and faulting instructions skip the bus and go straight to DONE.
module lsu_mem_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned F3_WIDTH   = 3
) (
    input  logic                    clk,
    input  logic                    rstn,
    // EXU side
    input  logic                    Evalid,
    output logic                    Mready,
    input  logic                    MemRead,
    input  logic                    MemWrite,
    input  logic [F3_WIDTH-1:0]     Funct3,
    input  logic [DATA_WIDTH-1:0]   ALUResult,
    input  logic [DATA_WIDTH-1:0]   WriteData,
    // WBU side
    output logic                    Mvalid,
    input  logic                    Wready,
    output logic [DATA_WIDTH-1:0]   ReadData,
    output logic                    MemFault,
    // Data bus
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_we,
    output logic [DATA_WIDTH-1:0]   mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_req_wstrb,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata,
    input  logic                    mem_rsp_err
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRsp,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Latched instruction fields
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic [F3_WIDTH-1:0]   f3_q, f3_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    // Result towards WBU
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  fault_q, fault_d;

    // Decode of the incoming instruction
    logic                  in_is_mem;
    logic                  in_f3_ok;
    logic                  in_misalign;

    // Bus-side helpers
    logic                  is_store;
    logic [4:0]            lane_shamt;
    logic [DATA_WIDTH-1:0] rsp_shifted;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [STRB_WIDTH-1:0] store_strb;
    logic [DATA_WIDTH-1:0] store_data;

    // Classify the instruction offered by EXU: legality of funct3 and alignment
    always_comb begin
        in_is_mem   = MemRead | MemWrite;
        in_f3_ok    = 1'b0;
        in_misalign = 1'b0;
        case (Funct3)
            3'b000, 3'b001, 3'b010: in_f3_ok = 1'b1;
            // LBU/LHU only exist as loads; a load wins when both flags are set
            3'b100, 3'b101:         in_f3_ok = MemRead;
            default:                in_f3_ok = 1'b0;
        endcase
        if (Funct3[1:0] == 2'b01) begin
            in_misalign = ALUResult[0];
        end else if (Funct3[1:0] == 2'b10) begin
            in_misalign = (ALUResult[1:0] != 2'b00);
        end
    end

    // Store lane placement and load alignment/extension from the latched fields
    always_comb begin
        is_store    = wr_q & ~rd_q;
        lane_shamt  = {addr_q[1:0], 3'b000};
        rsp_shifted = mem_rsp_rdata >> lane_shamt;
        store_strb  = '0;
        store_data  = '0;
        case (f3_q[1:0])
            2'b00: begin
                store_strb = STRB_WIDTH'(1) << addr_q[1:0];
                store_data = {STRB_WIDTH{wdata_q[7:0]}};
            end
            2'b01: begin
                store_strb = STRB_WIDTH'(3) << addr_q[1:0];
                store_data = {(STRB_WIDTH / 2){wdata_q[15:0]}};
            end
            default: begin
                store_strb = '1;
                store_data = wdata_q;
            end
        endcase
        case (f3_q)
            3'b000:  load_ext = {{(DATA_WIDTH - 8){rsp_shifted[7]}}, rsp_shifted[7:0]};
            3'b001:  load_ext = {{(DATA_WIDTH - 16){rsp_shifted[15]}}, rsp_shifted[15:0]};
            3'b100:  load_ext = {{(DATA_WIDTH - 8){1'b0}}, rsp_shifted[7:0]};
            3'b101:  load_ext = {{(DATA_WIDTH - 16){1'b0}}, rsp_shifted[15:0]};
            default: load_ext = rsp_shifted;
        endcase
    end

    // Next-state logic: accept in IDLE, bus request/response, hold result until WBU takes it
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        unique case (state_q)
            StIdle: begin
                if (Evalid) begin
                    rd_d    = MemRead;
                    wr_d    = MemWrite;
                    f3_d    = Funct3;
                    addr_d  = ALUResult;
                    wdata_d = WriteData;
                    rdata_d = '0;
                    fault_d = 1'b0;
                    if (!in_is_mem) begin
                        state_d = StDone;
                    end else if (!in_f3_ok || in_misalign) begin
                        fault_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                // A response in this cycle is illegal on the bus and is not looked at
                if (mem_req_ready) begin
                    state_d = StRsp;
                end
            end
            StRsp: begin
                if (mem_rsp_valid) begin
                    rdata_d = rd_q ? load_ext : '0;
                    fault_d = mem_rsp_err;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (Wready) begin
                    fault_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // Handshake and bus outputs, all driven from registered state
    always_comb begin
        Mready        = (state_q == StIdle);
        Mvalid        = (state_q == StDone);
        ReadData      = rdata_q;
        MemFault      = fault_q;
        mem_req_valid = (state_q == StReq);
        mem_req_we    = is_store;
        mem_req_addr  = {addr_q[DATA_WIDTH-1:2], 2'b00};
        mem_req_wstrb = is_store ? store_strb : '0;
        mem_req_wdata = is_store ? store_data : '0;
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: hand-computed vectors stepped one clock at a time.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        Evalid, Mready, MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult, WriteData;
    logic        Mvalid, Wready;
    logic [31:0] ReadData;
    logic        MemFault;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        mem_rsp_err;

    int tests  = 0;
    int failed = 0;

    lsu_mem_stage dut (
        .clk           (clk),
        .rstn          (rstn),
        .Evalid        (Evalid),
        .Mready        (Mready),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .Funct3        (Funct3),
        .ALUResult     (ALUResult),
        .WriteData     (WriteData),
        .Mvalid        (Mvalid),
        .Wready        (Wready),
        .ReadData      (ReadData),
        .MemFault      (MemFault),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wstrb (mem_req_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .mem_rsp_err   (mem_rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sampling and driving happen 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction in IDLE and let it be accepted on the next edge
    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        Evalid    = 1'b1;
        MemRead   = rd;
        MemWrite  = wr;
        Funct3    = f3;
        ALUResult = addr;
        WriteData = wd;
        check("issue_mready", Mready, 1);
        step();
        Evalid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_mready"}, Mready, 1);
        check({tag, "_mvalid"}, Mvalid, 0);
        check({tag, "_reqv"}, mem_req_valid, 0);
    endtask

    initial begin
        rstn = 1'b0; Evalid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b0;
        ALUResult = 32'h0; WriteData = 32'h0; Wready = 1'b1; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0; mem_rsp_err = 1'b0;
        step(); step();

        // Reset state
        check_idle("rst");
        check("rst_rdata", ReadData, 32'h0);
        check("rst_fault", MemFault, 0);
        rstn = 1'b1;
        step();

        // ALU op: Mvalid one cycle after acceptance, no bus activity
        issue(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h5555_5555);
        check("alu_mvalid", Mvalid, 1);
        check("alu_rdata", ReadData, 32'h0);
        check("alu_fault", MemFault, 0);
        check("alu_reqv", mem_req_valid, 0);
        check("alu_mready", Mready, 0);
        step();
        check_idle("alu_ret");

        // LB 0x80000003, zero-wait bus; a response alongside ready must be ignored
        mem_req_ready = 1'b1;
        issue(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0);
        check("lb_reqv", mem_req_valid, 1);
        check("lb_addr", mem_req_addr, 32'h8000_0000);
        check("lb_we", mem_req_we, 0);
        check("lb_wstrb", {28'h0, mem_req_wstrb}, 32'h0);
        check("lb_c1_mvalid", Mvalid, 0);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1111_1111;
        step();
        check("lb_c2_mvalid", Mvalid, 0);
        check("lb_c2_reqv", mem_req_valid, 0);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h80FF_1234;
        step();
        mem_rsp_valid = 1'b0;
        check("lb_c3_mvalid", Mvalid, 1);
        check("lb_rdata", ReadData, 32'hFFFF_FF80);
        check("lb_fault", MemFault, 0);
        step();
        check_idle("lb_ret");

        // SH 0xABCD at 0x80000002 with ready held off for 4 cycles
        mem_req_ready = 1'b0;
        issue(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h0000_ABCD);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) mem_req_ready = 1'b1;
            check("sh_reqv", mem_req_valid, 1);
            check("sh_addr", mem_req_addr, 32'h8000_0000);
            check("sh_we", mem_req_we, 1);
            check("sh_wstrb", {28'h0, mem_req_wstrb}, 32'h0000_000C);
            check("sh_wdata", mem_req_wdata, 32'hABCD_ABCD);
            step();
        end
        mem_req_ready = 1'b0;
        check("sh_rsp_reqv", mem_req_valid, 0);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hDEAD_BEEF;
        step();
        mem_rsp_valid = 1'b0;
        check("sh_mvalid", Mvalid, 1);
        check("sh_rdata", ReadData, 32'h0);
        check("sh_fault", MemFault, 0);
        step();

        // Misaligned LW: no request, fault next cycle, fault cleared after handshake
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'h0);
        check("lwmis_mvalid", Mvalid, 1);
        check("lwmis_fault", MemFault, 1);
        check("lwmis_reqv", mem_req_valid, 0);
        step();
        check_idle("lwmis_ret");
        check("lwmis_clr", MemFault, 0);

        // Illegal funct3 on a store faults without touching the bus
        issue(1'b0, 1'b1, 3'b100, 32'h8000_0000, 32'h0);
        check("badf3_fault", MemFault, 1);
        check("badf3_reqv", mem_req_valid, 0);
        step();

        // LHU at 0x80000002, rdata 0xBEEF0000
        mem_req_ready = 1'b1;
        issue(1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'h0);
        check("lhu_reqv", mem_req_valid, 1);
        step();
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hBEEF_0000;
        step();
        mem_rsp_valid = 1'b0;
        check("lhu_rdata", ReadData, 32'h0000_BEEF);
        check("lhu_fault", MemFault, 0);
        step();

        // Both MemRead and MemWrite: LBU at 0x1001 behaves as a load
        issue(1'b1, 1'b1, 3'b100, 32'h0000_1001, 32'hFFFF_FFFF);
        check("both_we", mem_req_we, 0);
        check("both_wstrb", {28'h0, mem_req_wstrb}, 32'h0);
        check("both_addr", mem_req_addr, 32'h0000_1000);
        step();
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0000_A500;
        step();
        mem_rsp_valid = 1'b0;
        check("both_rdata", ReadData, 32'h0000_00A5);
        step();

        // Backpressure: result held 5 cycles, a waiting ALU op accepted only after release
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'h0);
        step();
        Wready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1234_5678;
        step();
        Evalid = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000;
        mem_rsp_rdata = 32'h0BAD_0BAD;
        for (int i = 0; i < 5; i++) begin
            check("bp_mvalid", Mvalid, 1);
            check("bp_rdata", ReadData, 32'h1234_5678);
            check("bp_fault", MemFault, 0);
            check("bp_mready", Mready, 0);
            step();
        end
        mem_rsp_valid = 1'b0;
        Wready = 1'b1;
        check("bp_rel_mvalid", Mvalid, 1);
        step();
        check_idle("bp_ret");
        step();
        Evalid = 1'b0;
        check("bp_next_mvalid", Mvalid, 1);
        check("bp_next_rdata", ReadData, 32'h0);
        step();

        // Reset while in RSP, then a stray response
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0008, 32'h0);
        step();
        check("rr_rsp_mvalid", Mvalid, 0);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        check_idle("rr_rst");
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hCAFE_F00D;
        step();
        mem_rsp_valid = 1'b0;
        check_idle("rr_late");
        check("rr_late_rdata", ReadData, 32'h0);
        step();
        check_idle("rr_late2");

        // Bus error on a load
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0);
        step();
        mem_rsp_valid = 1'b1; mem_rsp_err = 1'b1; mem_rsp_rdata = 32'h0;
        step();
        mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
        check("err_mvalid", Mvalid, 1);
        check("err_fault", MemFault, 1);
        step();
        check("err_clr", MemFault, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Memory-access stage of the multicycle RV32 core. Sits between EXU (upstream) and WBU (downstream).
- Accepts one instruction per handshake from EXU and performs at most one data-bus transaction for it.
- Aligns and extends load data, then presents ReadData to WBU with an Mvalid/Wready handshake.
- Instructions that do not access memory pass through with a single-cycle bubble.

Parameters:
- DATA_WIDTH, 32, data and address width (RV32 only).
- F3_WIDTH, 3, width of the funct3 size/sign code.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset.
- Evalid  input  1  EXU has a valid instruction.
- Mready  output  1  stage can accept a new instruction.
- MemRead  input  1  instruction is a load.
- MemWrite  input  1  instruction is a store.
- Funct3  input  3  access size and sign.
- ALUResult  input  32  effective byte address.
- WriteData  input  32  store data (rs2).
- Mvalid  output  1  result is valid for WBU.
- Wready  input  1  WBU can accept a result.
- ReadData  output  32  aligned, extended load data.
- MemFault  output  1  misaligned access or bus error, valid with Mvalid.
- mem_req_valid  output  1  bus request.
- mem_req_ready  input  1  bus accepts the request.
- mem_req_we  output  1  1 = write.
- mem_req_addr  output  32  word-aligned address ({ALUResult[31:2],2'b0}).
- mem_req_wdata  output  32  lane-shifted store data.
- mem_req_wstrb  output  4  byte enables.
- mem_rsp_valid  input  1  bus response.
- mem_rsp_rdata  input  32  read data.
- mem_rsp_err  input  1  bus error.

Behaviour:
- Reset: rstn is synchronous, active-low; clock is clk.
  - State goes to IDLE.
  - Mready=1, Mvalid=0, mem_req_valid=0, ReadData=0, MemFault=0.
  - Reset mid-transaction abandons the transaction; any later mem_rsp_valid is ignored until a new request is issued.
- FSM states: IDLE, REQ, RSP, DONE.
  - Mready=1 only in IDLE.
  - Mvalid=1 only in DONE.
- IDLE:
  - On Evalid, latch MemRead, MemWrite, Funct3, ALUResult and WriteData.
  - If neither MemRead nor MemWrite: go to DONE, ReadData=0.
  - If misaligned (halfword with addr[0]=1, or word with addr[1:0]!=0): go to DONE, MemFault=1, no bus request.
  - Otherwise go to REQ.
  - If MemRead and MemWrite are both 1, treat as a load.
- REQ:
  - mem_req_valid=1. All mem_req_* fields come from latched values and stay stable until mem_req_ready.
  - On mem_req_ready, go to RSP.
- RSP:
  - Wait for mem_rsp_valid.
  - Capture the extended load data, or 0 for stores.
  - MemFault = mem_rsp_err.
  - Go to DONE.
  - A response arriving in the same cycle as mem_req_ready is not legal for the bus; it is ignored.
- DONE:
  - Hold Mvalid, ReadData and MemFault stable until Wready.
  - On Mvalid&&Wready, go to IDLE and clear MemFault.
- Latency:
  - Non-memory instruction: Evalid accepted in cycle 0, Mvalid in cycle 1.
  - Memory instruction with zero-wait bus: Mvalid in cycle 3 (REQ in cycle 1, response in cycle 2).
- Store lanes (b = addr[1:0]):
  - SB (000): wstrb = 4'b0001<<b; wdata = {4{rs2[7:0]}}.
  - SH (001): wstrb = 4'b0011<<b; wdata = {2{rs2[15:0]}}.
  - SW (010): wstrb = 4'b1111; wdata = rs2.
  - Loads drive wstrb=0.
- Load extraction: shift rdata right by 8*b, then:
  - LB (000): sign-extend bits [7:0].
  - LH (001): sign-extend bits [15:0].
  - LW (010): whole word.
  - LBU (100): zero-extend bits [7:0].
  - LHU (101): zero-extend bits [15:0].
  - Any other Funct3 on a memory op: MemFault=1, no bus request.
- No pipelining: a single instruction is in flight. Evalid while not IDLE is not accepted.

Test Plan:
- ALU op with Evalid=1, MemRead=MemWrite=0, Wready=1 -> Mvalid=1 exactly one cycle after acceptance, ReadData=0, no mem_req_valid.
- LB at addr 0x80000003, rdata=0x80FF_1234, zero-wait bus -> mem_req_addr=0x80000000, ReadData=0xFFFFFF80, MemFault=0, Mvalid 3 cycles after accept.
- SH rs2=0x0000ABCD at addr 0x80000002, mem_req_ready delayed 4 cycles -> request fields stable throughout, wstrb=4'b1100, wdata=0xABCDABCD, ReadData=0.
- LW at addr 0x80000002 -> no bus request, MemFault=1, Mvalid next cycle; LHU at 0x80000002 with rdata=0xBEEF0000 -> ReadData=0x0000BEEF.
- Backpressure: Wready=0 for 5 cycles in DONE -> Mvalid, ReadData and MemFault unchanged and Mready=0; a second Evalid is not accepted until the cycle after Wready=1.
- rstn=0 asserted while in RSP -> next cycle IDLE, Mready=1, Mvalid=0; a late mem_rsp_valid has no effect. mem_rsp_err=1 on a load -> MemFault=1 with Mvalid.
